// File: rtl/mips_pkg.sv
// Shared MIPS types: mul/div operation encoding and the mul/div FSM states.
package mips_pkg;

  localparam int MULDIV_OP_WIDTH = 2;

  typedef enum logic [MULDIV_OP_WIDTH-1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Controller <-> mul/div unit bundle: operation launch, MTHI/MTLO writes, HI/LO and status.
// Handshake: start is taken only when busy=0; busy stays high until the result is written,
// then done pulses for one cycle with HI/LO already updated. abort drops an in-flight op.
interface mips_muldiv_if
  import mips_pkg::*;
#(
  parameter int XLEN = 32
);
  logic             start;
  muldiv_op_e       op;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic             abort;
  logic             hi_write;
  logic             lo_write;
  logic [XLEN-1:0]  wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [XLEN-1:0]  hi_reg;
  logic [XLEN-1:0]  lo_reg;

  modport master (
    output start, op, operand_a, operand_b, abort, hi_write, lo_write, wr_data,
    input  busy, done, div_by_zero, hi_reg, lo_reg
  );

  modport slave (
    input  start, op, operand_a, operand_b, abort, hi_write, lo_write, wr_data,
    output busy, done, div_by_zero, hi_reg, lo_reg
  );
endinterface

// File: rtl/mips_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mips_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);
  logic [XLEN:0] shifted;

  // The true difference always fits XLEN bits, so the subtract can be done modulo 2^XLEN.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
  end
endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with its own HI/LO pair.
// Optional MULDIV_FAST_MULT_EN: multiplies use a single-cycle multiplier and skip RUN.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mips_muldiv_if.slave  md,
  output muldiv_state_e state_dbg
);
  localparam int CNT_W = $clog2(XLEN + 1);
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST_MULT = 1'b1;
`else
  localparam bit FAST_MULT = 1'b0;
`endif

  muldiv_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  // opnd_q: multiplicand or divisor. acc_hi_q/acc_lo_q: product halves, or remainder/quotient.
  logic [XLEN-1:0] opnd_q, acc_hi_q, acc_lo_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            is_div_q, neg_q, neg_rem_q;
  logic            done_q, dbz_q;

  logic [XLEN-1:0] a_abs, b_abs;
  logic            op_signed;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_rem;
  logic            div_qbit;
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;
  logic            div_zero;

  function automatic logic [XLEN-1:0] abs_v(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  mips_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (acc_hi_q),
    .dividend_bit (acc_lo_q[XLEN-1]),
    .divisor      (opnd_q),
    .rem_out      (div_rem),
    .q_bit        (div_qbit)
  );

  always_comb begin
    op_signed = op_is_signed(md.op);
    a_abs     = op_signed ? abs_v(md.operand_a) : md.operand_a;
    b_abs     = op_signed ? abs_v(md.operand_b) : md.operand_b;
    // Shift-add: add the multiplicand when the current multiplier LSB is set.
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  end

  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    prod_raw = {{XLEN{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_lo_q};
`else
    prod_raw = {acc_hi_q, acc_lo_q};
`endif
    prod_fix = neg_q ? -prod_raw : prod_raw;
    div_zero = (opnd_q == '0);
    quot_fix = div_zero ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
    // With a zero divisor the remainder path ends holding |a|, so this restores operand_a.
    rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          if (FAST_MULT && !op_is_div(md.op)) state_d = FINISH;
          else                                state_d = RUN;
        end
      end
      RUN: begin
        if (md.abort)                    state_d = IDLE;
        else if (cnt_q == CNT_W'(1))     state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (md.hi_write) hi_q <= md.wr_data;
          if (md.lo_write) lo_q <= md.wr_data;
          if (md.start) begin
            is_div_q  <= op_is_div(md.op);
            neg_q     <= op_signed & (md.operand_a[XLEN-1] ^ md.operand_b[XLEN-1]);
            neg_rem_q <= op_signed & op_is_div(md.op) & md.operand_a[XLEN-1];
            opnd_q    <= op_is_div(md.op) ? b_abs : a_abs;
            acc_lo_q  <= op_is_div(md.op) ? a_abs : b_abs;
            acc_hi_q  <= '0;
            cnt_q     <= CNT_W'(XLEN);
          end
        end
        RUN: begin
          if (md.abort) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (is_div_q) begin
              acc_hi_q <= div_rem;
              acc_lo_q <= {acc_lo_q[XLEN-2:0], div_qbit};
            end else begin
              acc_hi_q <= mul_sum[XLEN:1];
              acc_lo_q <= {mul_sum[0], acc_lo_q[XLEN-1:1]};
            end
          end
        end
        FINISH: begin
          if (!md.abort) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              hi_q  <= rem_fix;
              lo_q  <= quot_fix;
              dbz_q <= div_zero;
            end else begin
              hi_q  <= prod_fix[2*XLEN-1:XLEN];
              lo_q  <= prod_fix[XLEN-1:0];
              dbz_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md.busy        = (state_q != IDLE);
  assign md.done        = done_q;
  assign md.div_by_zero = dbz_q;
  assign md.hi_reg      = hi_q;
  assign md.lo_reg      = lo_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: hand-computed HI/LO, latency, abort and reset cases.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 2;
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_LAT = XLEN + 2;
  localparam int MUL_BUSY = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  muldiv_state_e state_dbg;
  int tests_run = 0;
  int tests_failed = 0;

  mips_muldiv_if #(.XLEN(XLEN)) bus ();

  mips_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md        (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Drivers
  task automatic launch(input muldiv_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic hw, input logic [XLEN-1:0] hw_data);
    @(negedge clk);
    bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.start = 1'b1;
    bus.hi_write = hw; bus.wr_data = hw_data;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_write = 1'b0;
  endtask

  // Called at the first negedge after the start edge; lat is cycles after that edge.
  task automatic wait_done(output int lat, output int busy_n);
    int overlap;
    lat = -1; busy_n = 0; overlap = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done && bus.busy) overlap = 1;
      if (bus.done) begin lat = i; break; end
    end
    tests_run++;
    if (overlap != 0) begin
      tests_failed++; $display("FAIL done_with_busy: done seen while busy=1");
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.hi_reg !== '0 || bus.lo_reg !== '0
        || state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h state=%0d, want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.hi_reg, bus.lo_reg, state_dbg);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu_max();
    int lat, bn;
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== MUL_LAT) begin tests_failed++; $display("FAIL multu_lat: got %0d want %0d", lat, MUL_LAT); end
    tests_run++;
    if (bn !== MUL_BUSY) begin tests_failed++; $display("FAIL multu_busy: got %0d want %0d", bn, MUL_BUSY); end
    tests_run++;
    if (bus.hi_reg !== 32'hFFFF_FFFE || bus.lo_reg !== 32'h0000_0001) begin
      tests_failed++; $display("FAIL multu_max: hi=%h lo=%h want fffffffe 00000001", bus.hi_reg, bus.lo_reg);
    end
  endtask

  task automatic test_mult_signed();
    int lat, bn;
    launch(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (bus.hi_reg !== 32'hFFFF_FFFF || bus.lo_reg !== 32'hFFFF_FFEB) begin
      tests_failed++; $display("FAIL mult_neg: hi=%h lo=%h want ffffffff ffffffeb", bus.hi_reg, bus.lo_reg);
    end
    launch(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (bus.hi_reg !== 32'h4000_0000 || bus.lo_reg !== 32'h0) begin
      tests_failed++; $display("FAIL mult_minmin: hi=%h lo=%h want 40000000 00000000", bus.hi_reg, bus.lo_reg);
    end
  endtask

  task automatic test_div();
    int lat, bn;
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== DIV_LAT) begin tests_failed++; $display("FAIL div_lat: got %0d want %0d", lat, DIV_LAT); end
    tests_run++;
    if (bus.lo_reg !== 32'hFFFF_FFFD || bus.hi_reg !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL div_neg7_2: lo=%h hi=%h want fffffffd ffffffff", bus.lo_reg, bus.hi_reg);
    end
    launch(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (bus.lo_reg !== 32'hFFFF_FFFD || bus.hi_reg !== 32'd1) begin
      tests_failed++; $display("FAIL div_7_neg2: lo=%h hi=%h want fffffffd 00000001", bus.lo_reg, bus.hi_reg);
    end
    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (bus.lo_reg !== 32'h8000_0000 || bus.hi_reg !== 32'h0) begin
      tests_failed++; $display("FAIL div_ovf: lo=%h hi=%h want 80000000 00000000", bus.lo_reg, bus.hi_reg);
    end
    launch(MD_DIVU, 32'd100, 32'd7, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (bus.lo_reg !== 32'd14 || bus.hi_reg !== 32'd2 || bus.div_by_zero !== 1'b0) begin
      tests_failed++; $display("FAIL divu_100_7: lo=%h hi=%h dbz=%b want e 2 0", bus.lo_reg, bus.hi_reg, bus.div_by_zero);
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bn;
    launch(MD_DIVU, 32'd7, 32'd0, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== DIV_LAT) begin tests_failed++; $display("FAIL dbz_lat: got %0d want %0d", lat, DIV_LAT); end
    tests_run++;
    if (bus.lo_reg !== 32'hFFFF_FFFF || bus.hi_reg !== 32'd7 || bus.div_by_zero !== 1'b1) begin
      tests_failed++; $display("FAIL dbz_divu: lo=%h hi=%h dbz=%b want ffffffff 7 1", bus.lo_reg, bus.hi_reg, bus.div_by_zero);
    end
    launch(MD_MULTU, 32'd2, 32'd3, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (bus.lo_reg !== 32'd6 || bus.hi_reg !== 32'd0 || bus.div_by_zero !== 1'b0) begin
      tests_failed++; $display("FAIL dbz_clear: lo=%h hi=%h dbz=%b want 6 0 0", bus.lo_reg, bus.hi_reg, bus.div_by_zero);
    end
    launch(MD_DIV, 32'hFFFF_FFF6, 32'd0, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (bus.lo_reg !== 32'hFFFF_FFFF || bus.hi_reg !== 32'hFFFF_FFF6 || bus.div_by_zero !== 1'b1) begin
      tests_failed++; $display("FAIL dbz_div_neg: lo=%h hi=%h dbz=%b want ffffffff fffffff6 1", bus.lo_reg, bus.hi_reg, bus.div_by_zero);
    end
  endtask

  task automatic test_mt_write();
    int lat, bn;
    @(negedge clk);
    bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wr_data = 32'h0000_A5A5;
    @(negedge clk);
    bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    tests_run++;
    if (bus.hi_reg !== 32'h0000_A5A5 || bus.lo_reg !== 32'h0000_A5A5) begin
      tests_failed++; $display("FAIL mt_both: hi=%h lo=%h want a5a5 a5a5", bus.hi_reg, bus.lo_reg);
    end
    launch(MD_MULTU, 32'd2, 32'd3, 1'b1, 32'h77);
    tests_run++;
    if (bus.hi_reg !== 32'h77) begin tests_failed++; $display("FAIL mthi_with_start: hi=%h want 77", bus.hi_reg); end
    wait_done(lat, bn);
    tests_run++;
    if (bus.hi_reg !== 32'd0 || bus.lo_reg !== 32'd6) begin
      tests_failed++; $display("FAIL mt_overwrite: hi=%h lo=%h want 0 6", bus.hi_reg, bus.lo_reg);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    lat = -1;
    launch(MD_MULTU, 32'd5, 32'd5, 1'b0, '0);
    for (int i = 1; i <= 100; i++) begin
      if (i > 1) @(negedge clk);
      if (i == 1) begin bus.start = 1'b1; bus.op = MD_DIVU; bus.operand_a = 32'd100; bus.operand_b = 32'd7; end
      if (i == 2) bus.start = 1'b0;
      if (bus.done) begin lat = i; break; end
    end
    tests_run++;
    if (lat !== MUL_LAT || bus.lo_reg !== 32'd25 || bus.hi_reg !== 32'd0) begin
      tests_failed++; $display("FAIL start_while_busy: lat=%0d lo=%h hi=%h want %0d 19 0", lat, bus.lo_reg, bus.hi_reg, MUL_LAT);
    end
  endtask

  task automatic test_abort();
    int lat, bn, saw_done;
    // Known state: HI=9 then overwritten, LO=all ones, div_by_zero=1.
    launch(MD_DIVU, 32'd9, 32'd0, 1'b0, '0);
    wait_done(lat, bn);
    @(negedge clk);
    bus.abort = 1'b1;   // abort alone in IDLE
    bus.hi_write = 1'b1; bus.wr_data = 32'h1234;
    @(negedge clk);
    bus.abort = 1'b0; bus.hi_write = 1'b0;
    tests_run++;
    if (bus.hi_reg !== 32'h1234 || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL mthi_idle: hi=%h busy=%b want 1234 0", bus.hi_reg, bus.busy);
    end
    // abort together with start in IDLE: start wins
    @(negedge clk);
    bus.op = MD_MULTU; bus.operand_a = 32'd5; bus.operand_b = 32'd5; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL start_beats_abort: busy=%b want 1", bus.busy); end
    saw_done = 0;
    for (int i = 2; i <= 50; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
      bus.abort = 1'b0; bus.hi_write = 1'b0;
      if (i == 5) begin bus.hi_write = 1'b1; bus.wr_data = 32'hDEAD; end
      if (i == 10) bus.abort = 1'b1;
      if (i == 11) begin
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: busy=%b want 0", bus.busy); end
      end
    end
    tests_run++;
    if (saw_done != 0 || bus.hi_reg !== 32'h1234 || bus.lo_reg !== 32'hFFFF_FFFF || bus.div_by_zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_keep: done_seen=%0d hi=%h lo=%h dbz=%b want 0 1234 ffffffff 1",
               saw_done, bus.hi_reg, bus.lo_reg, bus.div_by_zero);
    end
  endtask

  task automatic test_reset_mid();
    launch(MD_DIV, 32'd100, 32'd7, 1'b0, '0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.hi_reg !== '0 || bus.lo_reg !== '0
        || state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b done=%b dbz=%b hi=%h lo=%h state=%0d want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.hi_reg, bus.lo_reg, state_dbg);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mult_small();
    int lat, bn;
    launch(MD_MULTU, 32'd6, 32'd7, 1'b0, '0);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== MUL_LAT || bn !== MUL_BUSY || bus.lo_reg !== 32'd42 || bus.hi_reg !== 32'd0) begin
      tests_failed++;
      $display("FAIL multu_6_7: lat=%0d busy=%0d lo=%h hi=%h want %0d %0d 2a 0", lat, bn, bus.lo_reg, bus.hi_reg, MUL_LAT, MUL_BUSY);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = MD_MULT; bus.operand_a = '0; bus.operand_b = '0;
    bus.abort = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0; bus.wr_data = '0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div();
    test_div_by_zero();
    test_mt_write();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_mult_small();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
